// File: rtl/key_repeat_pkg.sv
// Shared types and constants for the key auto-repeat pulse generator.
package key_repeat_pkg;

  // FSM states of the repeat generator
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DAS    = 2'd1,
    REPEAT = 2'd2
  } state_e;

  localparam int DAS_FRAMES_DEF = 10;
  localparam int ARR_FRAMES_DEF = 3;
  localparam int CNT_W_DEF      = 5;
  localparam int REPEAT_CNT_W   = 8;

  // Saturating increment for the repeat status counter
  function automatic logic [REPEAT_CNT_W-1:0] sat_inc(input logic [REPEAT_CNT_W-1:0] v);
    logic [REPEAT_CNT_W-1:0] r;
    if (v == {REPEAT_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(REPEAT_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/key_repeat_gen_frame_counter.sv
// Frame counter shared by the DAS and REPEAT phases: counts enabled ticks,
// flags the tick that reaches the terminal value and self-clears on it.
module frame_counter
  import key_repeat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_inc_s;

  assign count_inc_s = count_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Terminal flag: this tick brings the count up to the terminal value
  always_comb begin
    term_o = 1'b0;
    if (tick_i && (count_inc_s == term_i)) begin
      term_o = 1'b1;
    end else begin
      term_o = 1'b0;
    end
  end

  // Next count: clear wins, terminal tick restarts, other ticks increment
  always_comb begin
    count_d = count_q;
    if (clear_i || term_o) begin
      count_d = {CNT_W{1'b0}};
    end else if (tick_i) begin
      count_d = count_inc_s;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/key_repeat_gen.sv
// Per-button action-pulse generator: one pulse on press, then auto-repeat
// pulses after a delayed-auto-shift interval, both measured in frame ticks.
// Optional build macro KEY_REPEAT_STATUS_EN adds the repeat_cnt status output.
module key_repeat_gen
  import key_repeat_pkg::*;
#(
  parameter int DAS_FRAMES = DAS_FRAMES_DEF,
  parameter int ARR_FRAMES = ARR_FRAMES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    key_level,
  input  logic                    tick_input,
  input  logic                    enable,
  output logic                    pulse_out,
`ifdef KEY_REPEAT_STATUS_EN
  output logic                    held,
  output logic [REPEAT_CNT_W-1:0] repeat_cnt
`else
  output logic                    held
`endif
);

  localparam logic [CNT_W-1:0] DAS_TERM = CNT_W'(DAS_FRAMES);
  localparam logic [CNT_W-1:0] ARR_TERM = CNT_W'(ARR_FRAMES);

  state_e           state_q;
  state_e           state_d;
  logic             key_prev_q;
  logic             pulse_q;
  logic             pulse_d;
  logic             held_q;
  logic             press_s;
  logic             cnt_tick_s;
  logic             cnt_clear_s;
  logic             cnt_term_s;
  logic [CNT_W-1:0] cnt_term_val_s;
  logic             rep_inc_s;
  logic             rep_clr_s;

  assign press_s = key_level & ~key_prev_q;

  // Only ticks seen while holding in an active phase advance the counter
  assign cnt_tick_s = tick_input & key_level & enable & (state_q != IDLE);

  // Terminal value follows the phase being timed
  always_comb begin
    cnt_term_val_s = ARR_TERM;
    if (state_q == DAS) begin
      cnt_term_val_s = DAS_TERM;
    end else begin
      cnt_term_val_s = ARR_TERM;
    end
  end

  frame_counter #(
    .CNT_W(CNT_W)
  ) u_frame_counter (
    .clock  (clock),
    .resetn (resetn),
    .clear_i(cnt_clear_s),
    .tick_i (cnt_tick_s),
    .term_i (cnt_term_val_s),
    .term_o (cnt_term_s)
  );

  // Next-state and pulse decision; release and disable win over any tick
  always_comb begin
    state_d     = state_q;
    pulse_d     = 1'b0;
    cnt_clear_s = 1'b0;
    rep_inc_s   = 1'b0;
    rep_clr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clear_s = 1'b1;
        if (enable && press_s) begin
          state_d   = DAS;
          pulse_d   = 1'b1;
          rep_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DAS: begin
        if (!enable || !key_level) begin
          state_d     = IDLE;
          cnt_clear_s = 1'b1;
        end else if (cnt_term_s) begin
          state_d   = REPEAT;
          pulse_d   = 1'b1;
          rep_inc_s = 1'b1;
        end else begin
          state_d = DAS;
        end
      end
      REPEAT: begin
        if (!enable || !key_level) begin
          state_d     = IDLE;
          cnt_clear_s = 1'b1;
        end else if (cnt_term_s) begin
          state_d   = REPEAT;
          pulse_d   = 1'b1;
          rep_inc_s = 1'b1;
        end else begin
          state_d = REPEAT;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_clear_s = 1'b1;
      end
    endcase
  end

  // State, edge-detect history and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      key_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_level;
      pulse_q    <= pulse_d;
      held_q     <= (state_d != IDLE);
    end
  end

  assign pulse_out = pulse_q;
  assign held      = held_q;

`ifdef KEY_REPEAT_STATUS_EN
  logic [REPEAT_CNT_W-1:0] repeat_cnt_q;
  logic [REPEAT_CNT_W-1:0] repeat_cnt_d;

  // Repeat count: cleared on a new press, saturating bump on each repeat
  always_comb begin
    repeat_cnt_d = repeat_cnt_q;
    if (rep_clr_s) begin
      repeat_cnt_d = {REPEAT_CNT_W{1'b0}};
    end else if (rep_inc_s) begin
      repeat_cnt_d = sat_inc(repeat_cnt_q);
    end else begin
      repeat_cnt_d = repeat_cnt_q;
    end
  end

  // Repeat count register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      repeat_cnt_q <= {REPEAT_CNT_W{1'b0}};
    end else begin
      repeat_cnt_q <= repeat_cnt_d;
    end
  end

  assign repeat_cnt = repeat_cnt_q;
`else
  logic unused_status_s;
  assign unused_status_s = rep_inc_s ^ rep_clr_s;
`endif

endmodule

// File: tb/tb_key_repeat_gen.sv
// Self-checking bench for key_repeat_gen (DAS=4, ARR=2, tick every 8 clocks
// in the directed part, random key/tick/enable/reset afterwards).
module tb_key_repeat_gen;

  localparam int DAS = 4;
  localparam int ARR = 2;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic key_level = 1'b0;
  logic tick_input = 1'b0;
  logic enable = 1'b0;
  logic pulse_out;
  logic held;
`ifdef KEY_REPEAT_STATUS_EN
  logic [7:0] repeat_cnt;
`endif

  key_repeat_gen #(
    .DAS_FRAMES(DAS),
    .ARR_FRAMES(ARR),
    .CNT_W(5)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .key_level (key_level),
    .tick_input(tick_input),
    .enable    (enable),
    .pulse_out (pulse_out),
`ifdef KEY_REPEAT_STATUS_EN
    .held      (held),
    .repeat_cnt(repeat_cnt)
`else
    .held      (held)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int npulse = 0;
  logic last_pulse = 1'b0;
  logic last_tick = 1'b0;

  // Behavioural reference: "active" hold session, ticks counted since press
  bit m_active = 1'b0;
  int m_ticks = 0;
  bit m_prev = 1'b0;
  int m_rep = 0;
  logic exp_pulse;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic k, input logic t, input logic e);
    key_level = k;
    tick_input = t;
    enable = e;
    @(posedge clock);
    exp_pulse = 1'b0;
    if (!resetn) begin
      m_active = 1'b0;
      m_ticks = 0;
      m_prev = 1'b0;
      m_rep = 0;
    end else begin
      if (!e) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (!k) begin
          m_active = 1'b0;
        end else if (t) begin
          m_ticks++;
          if (m_ticks == DAS || (m_ticks > DAS && ((m_ticks - DAS) % ARR) == 0)) begin
            exp_pulse = 1'b1;
            if (m_rep < 255) m_rep++;
          end
        end
      end else if (k && !m_prev) begin
        m_active = 1'b1;
        m_ticks = 0;
        m_rep = 0;
        exp_pulse = 1'b1;
      end
      m_prev = k;
    end
    cyc++;
    last_tick = t;
    #1;
    chk1("pulse_out", pulse_out, exp_pulse);
    chk1("held", held, logic'(m_active));
`ifdef KEY_REPEAT_STATUS_EN
    chkint("repeat_cnt", int'(repeat_cnt), m_rep);
`endif
    if (last_pulse === 1'b1) chk1("no_back_to_back", pulse_out, 1'b0);
    if (pulse_out === 1'b1) npulse++;
    last_pulse = pulse_out;
  endtask

  task automatic step_auto(input logic k, input logic e);
    step(k, logic'((cyc % 8) == 0), e);
  endtask

  // Run until n ticks have been applied (ends on the nth tick cycle)
  task automatic hold_ticks(input logic k, input logic e, input int n);
    int c = 0;
    while (c < n) begin
      if ((cyc % 8) == 0) c++;
      step_auto(k, e);
    end
  endtask

  task automatic align_off_tick(input logic k);
    while ((cyc % 8) != 3) step_auto(k, 1'b1);
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b1);
    resetn = 1'b1;

    // Press at cycle 10, hold 3 ticks, release: single pulse
    while (cyc < 10) step_auto(1'b0, 1'b1);
    npulse = 0;
    step_auto(1'b1, 1'b1);
    hold_ticks(1'b1, 1'b1, 3);
    step_auto(1'b0, 1'b1);
    step_auto(1'b0, 1'b1);
    chkint("short_hold_pulses", npulse, 1);

    // Hold through 10 ticks: press + 4 repeats
    align_off_tick(1'b0);
    npulse = 0;
    step_auto(1'b1, 1'b1);
    hold_ticks(1'b1, 1'b1, 10);
    step_auto(1'b0, 1'b1);
    chkint("long_hold_pulses", npulse, 5);

    // Press coincident with a tick: that tick does not count
    while ((cyc % 8) != 0) step_auto(1'b0, 1'b1);
    npulse = 0;
    step_auto(1'b1, 1'b1);
    hold_ticks(1'b1, 1'b1, 3);
    chkint("press_tick_after3", npulse, 1);
    hold_ticks(1'b1, 1'b1, 1);
    chkint("press_tick_after4", npulse, 2);
    step_auto(1'b0, 1'b1);

    // Release on the terminal DAS tick: no repeat
    align_off_tick(1'b0);
    npulse = 0;
    step_auto(1'b1, 1'b1);
    hold_ticks(1'b1, 1'b1, 3);
    while ((cyc % 8) != 0) step_auto(1'b1, 1'b1);
    step_auto(1'b0, 1'b1);
    chkint("release_on_terminal_pulses", npulse, 1);
    chk1("release_on_terminal_held", held, 1'b0);

    // Press while disabled, then enable with key held: nothing until re-press
    align_off_tick(1'b0);
    npulse = 0;
    repeat (3) step_auto(1'b1, 1'b0);
    hold_ticks(1'b1, 1'b1, 6);
    chkint("enable_late_pulses", npulse, 0);
    step_auto(1'b0, 1'b1);
    step_auto(1'b1, 1'b1);
    chk1("repress_pulse", pulse_out, 1'b1);
    step_auto(1'b0, 1'b1);

    // Reset while key held: held key counts as a press after reset
    step_auto(1'b1, 1'b1);
    step_auto(1'b1, 1'b1);
    resetn = 1'b0;
    step_auto(1'b1, 1'b1);
    step_auto(1'b1, 1'b1);
    resetn = 1'b1;
    npulse = 0;
    step_auto(1'b1, 1'b1);
    chkint("post_reset_press", npulse, 1);
    step_auto(1'b0, 1'b1);

`ifdef KEY_REPEAT_STATUS_EN
    // Long hold saturates the repeat counter; a re-press clears it
    align_off_tick(1'b0);
    step_auto(1'b1, 1'b1);
    hold_ticks(1'b1, 1'b1, 520);
    chkint("repeat_cnt_sat", int'(repeat_cnt), 255);
    step_auto(1'b0, 1'b1);
    chkint("repeat_cnt_hold_idle", int'(repeat_cnt), 255);
    step_auto(1'b1, 1'b1);
    chkint("repeat_cnt_cleared", int'(repeat_cnt), 0);
    step_auto(1'b0, 1'b1);
`endif

    // Random key/tick/enable/reset against the reference model
    begin
      logic k = 1'b0;
      logic e = 1'b1;
      logic t;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 19) == 0) k = ~k;
        if ($urandom_range(0, 99) == 0) e = ~e;
        resetn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
        t = (!last_tick && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
        step(k, t, e);
      end
      resetn = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
